spgd_iteration_sequencer: RTL

Top-level sequencer for one SPGD iteration on the `adc_clk` domain. It applies a +δ perturbation to the actuator/DAC path and waits a settle time, then triggers an ADC measurement and captures J+. It repeats with −δ to capture J−, then issues the signed metric difference dJ = J+ − J− with a one-cycle strobe to the gradient/update register. It replaces free-running ADC reset/write sequencing with a deterministic, timeout-protected two-sided measurement loop.

---
 rtl/spgd_pkg.sv | 37 +++
 rtl/spgd_iteration_sequencer_if.sv | 26 ++
 rtl/spgd_down_counter.sv | 31 +++
 rtl/spgd_iteration_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared types and constants for the SPGD two-sided measurement sequencer.
package spgd_pkg;

    localparam int ADC_W_DEFAULT = 14;

    localparam logic PERT_POS = 1'b1;
    localparam logic PERT_NEG = 1'b0;

    // Indices into the down-counter bank.
    localparam int CNT_SETTLE  = 0;
    localparam int CNT_TIMEOUT = 1;
    localparam int NUM_CNT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPLY_P  = 3'd1,
        ST_SETTLE_P = 3'd2,
        ST_MEAS_P   = 3'd3,
        ST_APPLY_N  = 3'd4,
        ST_SETTLE_N = 3'd5,
        ST_MEAS_N   = 3'd6,
        ST_UPDATE   = 3'd7
    } state_e;

    function automatic logic is_apply(input state_e s);
        return (s == ST_APPLY_P) || (s == ST_APPLY_N);
    endfunction

    function automatic logic is_settle(input state_e s);
        return (s == ST_SETTLE_P) || (s == ST_SETTLE_N);
    endfunction

    function automatic logic is_meas(input state_e s);
        return (s == ST_MEAS_P) || (s == ST_MEAS_N);
    endfunction

endpackage

// File: rtl/spgd_iteration_sequencer_if.sv
// ADC / actuator / update-register signal bundle of the SPGD sequencer.
interface spgd_iteration_sequencer_if #(
    parameter int ADC_W = spgd_pkg::ADC_W_DEFAULT
);
    logic                    enable;
    logic                    adc_done;
    logic signed [ADC_W-1:0] adc_data;
    logic                    ADC_RST;
    logic                    pert_load;
    logic                    pert_sign;
    logic signed [ADC_W:0]   dJ;
    logic                    dJ_valid;
    logic                    busy;
    logic                    timeout_err;
    logic [15:0]             iter_count;

    modport master (
        input  enable, adc_done, adc_data,
        output ADC_RST, pert_load, pert_sign, dJ, dJ_valid, busy, timeout_err, iter_count
    );

    modport slave (
        output enable, adc_done, adc_data,
        input  ADC_RST, pert_load, pert_sign, dJ, dJ_valid, busy, timeout_err, iter_count
    );
endinterface

// File: rtl/spgd_down_counter.sv
// 16-bit loadable down counter that parks at zero and flags it.
module spgd_down_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        dec_i,
    input  logic [15:0] load_val_i,
    output logic        zero_o
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 16'd0)) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 16'd0);
endmodule

// File: rtl/spgd_iteration_sequencer.sv
// One SPGD iteration: +delta settle/measure, -delta settle/measure, then strobe dJ = J+ - J-.
module spgd_iteration_sequencer
    import spgd_pkg::*;
#(
    parameter int ADC_W          = ADC_W_DEFAULT,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                        adc_clk,
    input logic                        RST_n,
    spgd_iteration_sequencer_if.master bus
);
    state_e                  state_q;
    logic                    adc_rst_q;
    logic                    pert_sign_q;
    logic signed [ADC_W-1:0] jp_q;
    logic signed [ADC_W:0]   dj_q;
    logic signed [ADC_W:0]   dj_d;
    logic                    timeout_err_q;
    logic [15:0]             iter_count_q;

    logic [NUM_CNT-1:0] cnt_load;
    logic [NUM_CNT-1:0] cnt_dec;
    logic [NUM_CNT-1:0] cnt_zero;
    logic [15:0]        cnt_val [NUM_CNT];

    // Timeout is loaded in the ADC_RST cycle so it hits zero TIMEOUT_CYCLES-1 cycles later.
    assign cnt_val[CNT_SETTLE]   = 16'(SETTLE_CYCLES - 1);
    assign cnt_val[CNT_TIMEOUT]  = 16'(TIMEOUT_CYCLES - 2);
    assign cnt_load[CNT_SETTLE]  = is_apply(state_q);
    assign cnt_dec[CNT_SETTLE]   = is_settle(state_q);
    assign cnt_load[CNT_TIMEOUT] = adc_rst_q;
    assign cnt_dec[CNT_TIMEOUT]  = is_meas(state_q) && !adc_rst_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            spgd_down_counter u_cnt (
                .clk        (adc_clk),
                .rst_n      (RST_n),
                .load_i     (cnt_load[gi]),
                .dec_i      (cnt_dec[gi]),
                .load_val_i (cnt_val[gi]),
                .zero_o     (cnt_zero[gi])
            );
        end
    endgenerate

    assign dj_d = {jp_q[ADC_W-1], jp_q} - {bus.adc_data[ADC_W-1], bus.adc_data};

    always_ff @(posedge adc_clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= ST_IDLE;
            adc_rst_q     <= 1'b0;
            pert_sign_q   <= PERT_POS;
            jp_q          <= '0;
            dj_q          <= '0;
            timeout_err_q <= 1'b0;
            iter_count_q  <= 16'd0;
        end else begin
            adc_rst_q <= 1'b0;
            // Dropping enable wins over everything, including a done in the same cycle.
            if ((state_q != ST_IDLE) && !bus.enable) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.enable) begin
                            state_q       <= ST_APPLY_P;
                            pert_sign_q   <= PERT_POS;
                            timeout_err_q <= 1'b0;
                        end
                    end
                    ST_APPLY_P: state_q <= ST_SETTLE_P;
                    ST_APPLY_N: state_q <= ST_SETTLE_N;
                    ST_SETTLE_P: begin
                        if (cnt_zero[CNT_SETTLE]) begin
                            state_q   <= ST_MEAS_P;
                            adc_rst_q <= 1'b1;
                        end
                    end
                    ST_SETTLE_N: begin
                        if (cnt_zero[CNT_SETTLE]) begin
                            state_q   <= ST_MEAS_N;
                            adc_rst_q <= 1'b1;
                        end
                    end
                    ST_MEAS_P: begin
                        if (!adc_rst_q) begin
                            if (bus.adc_done) begin
                                jp_q        <= bus.adc_data;
                                pert_sign_q <= PERT_NEG;
                                state_q     <= ST_APPLY_N;
                            end else if (cnt_zero[CNT_TIMEOUT]) begin
                                timeout_err_q <= 1'b1;
                                state_q       <= ST_IDLE;
                            end
                        end
                    end
                    ST_MEAS_N: begin
                        if (!adc_rst_q) begin
                            if (bus.adc_done) begin
                                dj_q         <= dj_d;
                                iter_count_q <= iter_count_q + 16'd1;
                                state_q      <= ST_UPDATE;
                            end else if (cnt_zero[CNT_TIMEOUT]) begin
                                timeout_err_q <= 1'b1;
                                state_q       <= ST_IDLE;
                            end
                        end
                    end
                    ST_UPDATE: begin
                        state_q     <= ST_APPLY_P;
                        pert_sign_q <= PERT_POS;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ADC_RST     = adc_rst_q;
    assign bus.pert_load   = is_apply(state_q);
    assign bus.pert_sign   = pert_sign_q;
    assign bus.dJ          = dj_q;
    assign bus.dJ_valid    = (state_q == ST_UPDATE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.iter_count  = iter_count_q;
endmodule
